// File: rtl/rx_byte_processor.sv
`default_nettype none
// ============================================================================
//  Module   : rx_byte_processor
//  Purpose  : USB host receive byte stage. Checks the PID, runs CRC16 over
//             DATA payloads, counts payload length and re-emits each packet
//             as a tagged stream: PID byte, data bytes, closing status byte.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_byte_processor #(
    parameter int MAX_PKT_BYTES = 1026
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rxByteIn,
    input  logic [1:0] rxCtrlIn,
    input  logic       rxStrobe,
    output logic [7:0] RXDataOut,
    output logic       RXDataValid,
    output logic [7:0] RXStreamStatusOut,
    output logic       rxPktActive
);

    localparam int              CNT_W     = $clog2(MAX_PKT_BYTES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT_BYTES);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(2);
    localparam logic [15:0]     CRC_INIT  = 16'hFFFF;
    localparam logic [15:0]     CRC_GOOD  = 16'hB001;
    localparam logic [15:0]     CRC_POLY  = 16'hA001;
    localparam logic [7:0]      TAG_DATA  = 8'h01;
    localparam logic [7:0]      TAG_CTRL  = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PID = 3'd1,
        S_DATA     = 3'd2,
        S_HS       = 3'd3,
        S_DROP     = 3'd4,
        S_STATUS   = 3'd5
    } state_t;

    // CRC16 over one byte, LSB first as it travelled on the wire
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) begin
                r = r ^ CRC_POLY;
            end
        end
        return r;
    endfunction

    state_t           state,     nxt_state;
    logic [15:0]      crc,       nxt_crc;
    logic [CNT_W-1:0] cnt,       nxt_cnt;
    logic             pid_err,   nxt_pid_err;
    logic             data_seq,  nxt_data_seq;
    logic             ack,       nxt_ack;
    logic             nak,       nxt_nak;
    logic             stall,     nxt_stall;
    logic             overflow,  nxt_overflow;
    logic             bit_stuff, nxt_bit_stuff;
    logic [7:0]       data_out,  nxt_data_out;
    logic             data_vld,  nxt_data_vld;
    logic [7:0]       stream,    nxt_stream;
    logic             active,    nxt_active;
    logic             clear_flags;

    logic             is_data;
    logic             is_sop;
    logic             is_eop;
    logic             is_abort;
    logic             crc_bad;
    logic [7:0]       status_base;

    assign is_data  = rxStrobe && (rxCtrlIn == 2'b00);
    assign is_sop   = rxStrobe && (rxCtrlIn == 2'b01);
    assign is_eop   = rxStrobe && (rxCtrlIn == 2'b10);
    assign is_abort = rxStrobe && (rxCtrlIn == 2'b11);

    // A payload shorter than two bytes cannot even hold its CRC
    assign crc_bad     = (crc != CRC_GOOD) || (cnt < MIN_CNT);
    assign status_base = {pid_err, data_seq, ack, stall, nak, overflow, 2'b00};

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            crc       <= CRC_INIT;
            cnt       <= '0;
            pid_err   <= 1'b0;
            data_seq  <= 1'b0;
            ack       <= 1'b0;
            nak       <= 1'b0;
            stall     <= 1'b0;
            overflow  <= 1'b0;
            bit_stuff <= 1'b0;
            data_out  <= 8'h00;
            data_vld  <= 1'b0;
            stream    <= 8'h00;
            active    <= 1'b0;
        end else begin
            state     <= nxt_state;
            crc       <= nxt_crc;
            cnt       <= nxt_cnt;
            pid_err   <= nxt_pid_err;
            data_seq  <= nxt_data_seq;
            ack       <= nxt_ack;
            nak       <= nxt_nak;
            stall     <= nxt_stall;
            overflow  <= nxt_overflow;
            bit_stuff <= nxt_bit_stuff;
            data_out  <= nxt_data_out;
            data_vld  <= nxt_data_vld;
            stream    <= nxt_stream;
            active    <= nxt_active;
        end
    end

    // Next-state, flag update and output selection
    always_comb begin
        nxt_state     = state;
        nxt_crc       = crc;
        nxt_cnt       = cnt;
        nxt_pid_err   = pid_err;
        nxt_data_seq  = data_seq;
        nxt_ack       = ack;
        nxt_nak       = nak;
        nxt_stall     = stall;
        nxt_overflow  = overflow;
        nxt_bit_stuff = bit_stuff;
        nxt_data_out  = 8'h00;
        nxt_data_vld  = 1'b0;
        nxt_stream    = 8'h00;
        nxt_active    = active;
        clear_flags   = 1'b0;

        case (state)
            // STATUS lasts one cycle; a strobe landing here is handled as idle
            S_IDLE, S_STATUS: begin
                if (state == S_STATUS) begin
                    nxt_state  = S_IDLE;
                    nxt_active = 1'b0;
                end
                if (is_sop) begin
                    nxt_state   = S_WAIT_PID;
                    nxt_active  = 1'b1;
                    clear_flags = 1'b1;
                end
            end

            S_WAIT_PID: begin
                if (is_data) begin
                    nxt_data_vld = 1'b1;
                    nxt_data_out = rxByteIn;
                    nxt_stream   = TAG_CTRL;
                    nxt_pid_err  = (rxByteIn[7:4] != ~rxByteIn[3:0]);
                    case (rxByteIn[1:0])
                        2'b11: begin
                            nxt_state    = S_DATA;
                            nxt_crc      = CRC_INIT;
                            nxt_cnt      = '0;
                            nxt_data_seq = rxByteIn[3];
                        end
                        2'b10: begin
                            nxt_state = S_HS;
                            nxt_ack   = (rxByteIn[3:0] == 4'b0010);
                            nxt_nak   = (rxByteIn[3:0] == 4'b1010);
                            nxt_stall = (rxByteIn[3:0] == 4'b1110);
                        end
                        default: begin
                            nxt_state = S_DROP;
                        end
                    endcase
                end else if (is_eop || is_abort) begin
                    nxt_state  = S_IDLE;
                    nxt_active = 1'b0;
                end else if (is_sop) begin
                    clear_flags = 1'b1;
                end
            end

            S_DATA: begin
                if (is_data) begin
                    if (cnt == MAX_CNT) begin
                        nxt_overflow = 1'b1;
                    end else begin
                        nxt_data_vld = 1'b1;
                        nxt_data_out = rxByteIn;
                        nxt_stream   = TAG_DATA;
                        nxt_crc      = crc16_byte(crc, rxByteIn);
                        nxt_cnt      = cnt + CNT_W'(1);
                    end
                end else if (is_eop) begin
                    nxt_state    = S_STATUS;
                    nxt_data_vld = 1'b1;
                    nxt_data_out = status_base | {6'b0, bit_stuff, crc_bad};
                    nxt_stream   = TAG_CTRL;
                end else if (is_abort) begin
                    nxt_state     = S_STATUS;
                    nxt_bit_stuff = 1'b1;
                    nxt_data_vld  = 1'b1;
                    nxt_data_out  = status_base | 8'h02;
                    nxt_stream    = TAG_CTRL;
                end else if (is_sop) begin
                    // Close the interrupted packet, then start the new one
                    nxt_state    = S_WAIT_PID;
                    nxt_data_vld = 1'b1;
                    nxt_data_out = status_base | 8'h02;
                    nxt_stream   = TAG_CTRL;
                    clear_flags  = 1'b1;
                end
            end

            S_HS: begin
                if (is_data) begin
                    nxt_pid_err = 1'b1;
                end else if (is_eop) begin
                    nxt_state    = S_STATUS;
                    nxt_data_vld = 1'b1;
                    nxt_data_out = status_base | {6'b0, bit_stuff, 1'b0};
                    nxt_stream   = TAG_CTRL;
                end else if (is_abort) begin
                    nxt_state     = S_STATUS;
                    nxt_bit_stuff = 1'b1;
                    nxt_data_vld  = 1'b1;
                    nxt_data_out  = status_base | 8'h02;
                    nxt_stream    = TAG_CTRL;
                end else if (is_sop) begin
                    nxt_state    = S_WAIT_PID;
                    nxt_data_vld = 1'b1;
                    nxt_data_out = status_base | 8'h02;
                    nxt_stream   = TAG_CTRL;
                    clear_flags  = 1'b1;
                end
            end

            S_DROP: begin
                if (is_eop || is_abort) begin
                    nxt_state  = S_IDLE;
                    nxt_active = 1'b0;
                end else if (is_sop) begin
                    nxt_state   = S_WAIT_PID;
                    clear_flags = 1'b1;
                end
            end

            default: begin
                nxt_state  = S_IDLE;
                nxt_active = 1'b0;
            end
        endcase

        // Every SOP starts the new packet with a clean flag set
        if (clear_flags) begin
            nxt_pid_err   = 1'b0;
            nxt_data_seq  = 1'b0;
            nxt_ack       = 1'b0;
            nxt_nak       = 1'b0;
            nxt_stall     = 1'b0;
            nxt_overflow  = 1'b0;
            nxt_bit_stuff = 1'b0;
        end
    end

    assign RXDataOut         = data_out;
    assign RXDataValid       = data_vld;
    assign RXStreamStatusOut = stream;
    assign rxPktActive       = active;

endmodule
`default_nettype wire

// File: tb/tb_rx_byte_processor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_byte_processor
//  Purpose  : Directed self-checking bench for rx_byte_processor, built with a
//             four-byte packet limit so the overflow path is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_byte_processor;

    localparam logic [1:0] C_DAT = 2'b00;
    localparam logic [1:0] C_SOP = 2'b01;
    localparam logic [1:0] C_EOP = 2'b10;
    localparam logic [1:0] C_ABT = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [7:0] rxByteIn;
    logic [1:0] rxCtrlIn;
    logic       rxStrobe;
    logic [7:0] RXDataOut;
    logic       RXDataValid;
    logic [7:0] RXStreamStatusOut;
    logic       rxPktActive;

    int n_checks = 0;
    int n_fails  = 0;

    rx_byte_processor #(
        .MAX_PKT_BYTES (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rxByteIn          (rxByteIn),
        .rxCtrlIn          (rxCtrlIn),
        .rxStrobe          (rxStrobe),
        .RXDataOut         (RXDataOut),
        .RXDataValid       (RXDataValid),
        .RXStreamStatusOut (RXStreamStatusOut),
        .rxPktActive       (rxPktActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC16, LSB first, used only for the overflow packet
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One strobe; the result is sampled on the falling edge after the capturing edge
    task automatic drive(input logic [1:0] c, input logic [7:0] b);
        @(negedge clk);
        rxCtrlIn = c;
        rxByteIn = b;
        rxStrobe = 1'b1;
        @(negedge clk);
        rxStrobe = 1'b0;
        rxCtrlIn = 2'b00;
        rxByteIn = 8'h00;
    endtask

    task automatic send_emit(input string tag, input logic [1:0] c, input logic [7:0] b,
                             input logic [7:0] exp_stream);
        drive(c, b);
        chk({tag, "_valid"},  {7'b0, RXDataValid}, 8'h01);
        chk({tag, "_data"},   RXDataOut, b);
        chk({tag, "_stream"}, RXStreamStatusOut, exp_stream);
    endtask

    task automatic send_quiet(input string tag, input logic [1:0] c, input logic [7:0] b);
        drive(c, b);
        chk({tag, "_valid"}, {7'b0, RXDataValid}, 8'h00);
    endtask

    // Terminating strobe: status byte next cycle, active falls one cycle later
    task automatic send_close(input string tag, input logic [1:0] c, input logic [7:0] exp_status);
        drive(c, 8'h00);
        chk({tag, "_valid"},  {7'b0, RXDataValid}, 8'h01);
        chk({tag, "_status"}, RXDataOut, exp_status);
        chk({tag, "_stream"}, RXStreamStatusOut, 8'h00);
        chk({tag, "_act_hi"}, {7'b0, rxPktActive}, 8'h01);
        @(negedge clk);
        chk({tag, "_after"},  {7'b0, RXDataValid}, 8'h00);
        chk({tag, "_act_lo"}, {7'b0, rxPktActive}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        logic [7:0]  exp_st;

        rst_n    = 1'b0;
        rxByteIn = 8'h00;
        rxCtrlIn = 2'b00;
        rxStrobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  {7'b0, RXDataValid}, 8'h00);
        chk("rst_data",   RXDataOut, 8'h00);
        chk("rst_stream", RXStreamStatusOut, 8'h00);
        chk("rst_active", {7'b0, rxPktActive}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle ignores stray data and EOP
        send_quiet("idle_data", C_DAT, 8'h55);
        send_quiet("idle_eop",  C_EOP, 8'h00);
        chk("idle_active", {7'b0, rxPktActive}, 8'h00);

        // DATA0 with correct CRC of empty payload
        drive(C_SOP, 8'h00);
        chk("sop_active", {7'b0, rxPktActive}, 8'h01);
        send_emit("d0_pid", C_DAT, 8'hC3, 8'h00);
        send_emit("d0_b0",  C_DAT, 8'h00, 8'h01);
        send_emit("d0_b1",  C_DAT, 8'h00, 8'h01);
        send_close("d0_end", C_EOP, 8'h00);

        // DATA1 with bad CRC
        drive(C_SOP, 8'h00);
        send_emit("d1_pid", C_DAT, 8'h4B, 8'h00);
        send_emit("d1_b0",  C_DAT, 8'h00, 8'h01);
        send_emit("d1_b1",  C_DAT, 8'h01, 8'h01);
        send_close("d1_end", C_EOP, 8'h41);

        // DATA1 with no payload: too short
        drive(C_SOP, 8'h00);
        send_emit("d1s_pid", C_DAT, 8'h4B, 8'h00);
        send_close("d1s_end", C_EOP, 8'h41);

        // Handshakes
        drive(C_SOP, 8'h00);
        send_emit("ack_pid", C_DAT, 8'hD2, 8'h00);
        send_close("ack_end", C_EOP, 8'h20);
        drive(C_SOP, 8'h00);
        send_emit("nak_pid", C_DAT, 8'h5A, 8'h00);
        send_close("nak_end", C_EOP, 8'h08);
        drive(C_SOP, 8'h00);
        send_emit("stl_pid", C_DAT, 8'h1E, 8'h00);
        send_close("stl_end", C_EOP, 8'h10);

        // Handshake followed by an extra byte
        drive(C_SOP, 8'h00);
        send_emit("ackx_pid", C_DAT, 8'hD2, 8'h00);
        send_quiet("ackx_extra", C_DAT, 8'h55);
        send_close("ackx_end", C_EOP, 8'hA0);

        // Corrupted PID decoding as ACK
        drive(C_SOP, 8'h00);
        send_emit("c2_pid", C_DAT, 8'hC2, 8'h00);
        send_close("c2_end", C_EOP, 8'hA0);

        // Corrupted PID decoding as DATA0, good CRC
        drive(C_SOP, 8'h00);
        send_emit("d3_pid", C_DAT, 8'hD3, 8'h00);
        send_emit("d3_b0",  C_DAT, 8'h00, 8'h01);
        send_emit("d3_b1",  C_DAT, 8'h00, 8'h01);
        send_close("d3_end", C_EOP, 8'h80);

        // Abort mid-payload: bit-stuff only, no CRC verdict
        drive(C_SOP, 8'h00);
        send_emit("ab_pid", C_DAT, 8'hC3, 8'h00);
        send_emit("ab_b0",  C_DAT, 8'h12, 8'h01);
        send_emit("ab_b1",  C_DAT, 8'h34, 8'h01);
        send_emit("ab_b2",  C_DAT, 8'h56, 8'h01);
        send_close("ab_end", C_ABT, 8'h02);

        // Token: only the PID is forwarded
        drive(C_SOP, 8'h00);
        send_emit("tok_pid", C_DAT, 8'h69, 8'h00);
        send_quiet("tok_b0", C_DAT, 8'h11);
        send_quiet("tok_eop", C_EOP, 8'h00);
        chk("tok_active", {7'b0, rxPktActive}, 8'h00);

        // EOP before any PID: nothing emitted
        drive(C_SOP, 8'h00);
        send_quiet("nopid_eop", C_EOP, 8'h00);
        chk("nopid_active", {7'b0, rxPktActive}, 8'h00);

        // Overflow: six bytes with a four-byte limit
        drive(C_SOP, 8'h00);
        send_emit("ov_pid", C_DAT, 8'hC3, 8'h00);
        c = 16'hFFFF;
        for (int i = 1; i <= 4; i++) begin
            send_emit("ov_fwd", C_DAT, 8'(i), 8'h01);
            c = ref_crc(c, 8'(i));
        end
        send_quiet("ov_drop5", C_DAT, 8'h05);
        send_quiet("ov_drop6", C_DAT, 8'h06);
        exp_st = 8'h04 | ((c != 16'hB001) ? 8'h01 : 8'h00);
        send_close("ov_end", C_EOP, exp_st);

        // SOP inside a DATA packet closes it and restarts cleanly
        drive(C_SOP, 8'h00);
        send_emit("re_pid", C_DAT, 8'hC3, 8'h00);
        send_emit("re_b0",  C_DAT, 8'h11, 8'h01);
        drive(C_SOP, 8'h00);
        chk("re_valid",  {7'b0, RXDataValid}, 8'h01);
        chk("re_status", RXDataOut, 8'h02);
        chk("re_active", {7'b0, rxPktActive}, 8'h01);
        send_emit("re2_pid", C_DAT, 8'hC3, 8'h00);
        send_emit("re2_b0",  C_DAT, 8'h00, 8'h01);
        send_emit("re2_b1",  C_DAT, 8'h00, 8'h01);
        send_close("re2_end", C_EOP, 8'h00);

        // Asynchronous reset between two data bytes
        drive(C_SOP, 8'h00);
        send_emit("rs_pid", C_DAT, 8'hC3, 8'h00);
        send_emit("rs_b0",  C_DAT, 8'h00, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_valid",  {7'b0, RXDataValid}, 8'h00);
        chk("rs_data",   RXDataOut, 8'h00);
        chk("rs_active", {7'b0, rxPktActive}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send_quiet("rs_post_data", C_DAT, 8'h00);
        drive(C_SOP, 8'h00);
        send_emit("rs2_pid", C_DAT, 8'hC3, 8'h00);
        send_emit("rs2_b0",  C_DAT, 8'h00, 8'h01);
        send_emit("rs2_b1",  C_DAT, 8'h00, 8'h01);
        send_close("rs2_end", C_EOP, 8'h00);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
